// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 command encodings, exception codes and sequencer states
package cp0_pkg;

   localparam logic [2:0] CP0_NONE = 3'b000;
   localparam logic [2:0] CP0_MTC0 = 3'b010;
   localparam logic [2:0] CP0_TRAP = 3'b011;
   localparam logic [2:0] CP0_ERET = 3'b100;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_OV  = 5'd12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRAP  = 2'd1,
      ST_ERET  = 2'd2,
      ST_REDIR = 2'd3
   } exc_state_t;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - two-flop synchronizer bank for the external interrupt lines
module irq_sync #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_async,
   output logic [W-1:0] o_sync
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt sequencer driving CP0 trap/ERET and fetch redirect
module exc_ctrl
   import cp0_pkg::*;
#(
   parameter logic [29:0] HANDLER_PC = 30'h0000_0C00,
   parameter int          NIRQ       = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_valid,
   input  logic [29:0]     wb_pc,
   input  logic            wb_syscall,
   input  logic            wb_ovf,
   input  logic            wb_eret,
   input  logic [NIRQ-1:0] irq,
   input  logic            status_ie,
   input  logic            status_exl,
   input  logic [NIRQ-1:0] status_im,
   input  logic [29:0]     cp0_epc,
   output logic [2:0]      wr_cp0op,
   output logic [31:0]     exc_epc,
   output logic [4:0]      exc_code,
   output logic            wb_kill,
   output logic            flush,
   output logic            redirect_valid,
   output logic [29:0]     redirect_pc
);

   exc_state_t r_state;
   exc_state_t w_state_nxt;

   logic [NIRQ-1:0] w_irq_s;
   logic            w_int_req;
   logic [2:0]      w_op_nxt;
   logic [31:0]     w_epc_nxt;
   logic [4:0]      w_code_nxt;
   logic [29:0]     w_target_nxt;

   logic [2:0]      r_wr_cp0op;
   logic [31:0]     r_exc_epc;
   logic [4:0]      r_exc_code;
   logic            r_flush;
   logic            r_redirect_valid;
   logic [29:0]     r_redirect_pc;

   irq_sync #(.W(NIRQ)) u_irq_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (irq),
      .o_sync  (w_irq_s)
   );

   assign w_int_req = status_ie & ~status_exl & (|(w_irq_s & status_im));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Latched EPC/code/target hold their value outside the cycle that loads them.
   always_comb begin
      w_state_nxt  = r_state;
      w_epc_nxt    = r_exc_epc;
      w_code_nxt   = r_exc_code;
      w_target_nxt = r_redirect_pc;
      unique case (r_state)
         ST_IDLE: begin
            if (wb_valid) begin
               if (wb_ovf) begin
                  w_state_nxt  = ST_TRAP;
                  w_epc_nxt    = {wb_pc, 2'b00};
                  w_code_nxt   = EXC_OV;
                  w_target_nxt = HANDLER_PC;
               end else if (wb_syscall) begin
                  w_state_nxt  = ST_TRAP;
                  w_epc_nxt    = {wb_pc, 2'b00};
                  w_code_nxt   = EXC_SYS;
                  w_target_nxt = HANDLER_PC;
               end else if (wb_eret) begin
                  w_state_nxt  = ST_ERET;
               end else if (w_int_req) begin
                  // The WB instruction commits, so the handler returns past it.
                  w_state_nxt  = ST_TRAP;
                  w_epc_nxt    = {wb_pc + 30'd1, 2'b00};
                  w_code_nxt   = EXC_INT;
                  w_target_nxt = HANDLER_PC;
               end
            end
         end
         ST_TRAP:  w_state_nxt = ST_REDIR;
         ST_ERET: begin
            w_state_nxt  = ST_REDIR;
            w_target_nxt = cp0_epc;
         end
         ST_REDIR: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_op_nxt = CP0_NONE;
      if (w_state_nxt == ST_TRAP)      w_op_nxt = CP0_TRAP;
      else if (w_state_nxt == ST_ERET) w_op_nxt = CP0_ERET;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cp0op       <= CP0_NONE;
         r_exc_epc        <= '0;
         r_exc_code       <= '0;
         r_flush          <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_wr_cp0op       <= w_op_nxt;
         r_exc_epc        <= w_epc_nxt;
         r_exc_code       <= w_code_nxt;
         r_flush          <= (w_state_nxt != ST_IDLE);
         r_redirect_valid <= (w_state_nxt == ST_REDIR);
         r_redirect_pc    <= w_target_nxt;
      end
   end

   assign wb_kill        = (r_state == ST_IDLE) & wb_valid & wb_ovf;
   assign wr_cp0op       = r_wr_cp0op;
   assign exc_epc        = r_exc_epc;
   assign exc_code       = r_exc_code;
   assign flush          = r_flush;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - scoreboard bench for exc_ctrl
module tb_exc_ctrl;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] epc;
      logic [4:0]  code;
      bit          chk_epc;
   } cmd_t;

   logic        clk;
   logic        rst_n;
   logic        wb_valid;
   logic [29:0] wb_pc;
   logic        wb_syscall;
   logic        wb_ovf;
   logic        wb_eret;
   logic [5:0]  irq;
   logic        status_ie;
   logic        status_exl;
   logic [5:0]  status_im;
   logic [29:0] cp0_epc;
   logic [2:0]  wr_cp0op;
   logic [31:0] exc_epc;
   logic [4:0]  exc_code;
   logic        wb_kill;
   logic        flush;
   logic        redirect_valid;
   logic [29:0] redirect_pc;

   int total;
   int bad;

   cmd_t        q_cmd[$];
   logic [29:0] q_redir[$];
   cmd_t        e_cmd;
   logic [29:0] e_pc;

   exc_ctrl #(.HANDLER_PC(30'h0000_0C00), .NIRQ(6)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wb_valid       (wb_valid),
      .wb_pc          (wb_pc),
      .wb_syscall     (wb_syscall),
      .wb_ovf         (wb_ovf),
      .wb_eret        (wb_eret),
      .irq            (irq),
      .status_ie      (status_ie),
      .status_exl     (status_exl),
      .status_im      (status_im),
      .cp0_epc        (cp0_epc),
      .wr_cp0op       (wr_cp0op),
      .exc_epc        (exc_epc),
      .exc_code       (exc_code),
      .wb_kill        (wb_kill),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one WB instruction for exactly one cycle; called at posedge+1.
   task automatic issue(input logic [29:0] pc, input logic sys, input logic ovf,
                        input logic er, input logic exp_kill);
      wb_valid   = 1'b1;
      wb_pc      = pc;
      wb_syscall = sys;
      wb_ovf     = ovf;
      wb_eret    = er;
      #1;
      check("wb_kill", {31'd0, wb_kill}, {31'd0, exp_kill});
      @(posedge clk);
      #1;
      wb_valid   = 1'b0;
      wb_syscall = 1'b0;
      wb_ovf     = 1'b0;
      wb_eret    = 1'b0;
   endtask

   task automatic push_trap(input logic [2:0] op, input logic [31:0] epc,
                            input logic [4:0] code, input bit ce, input logic [29:0] tgt);
      cmd_t c;
      c.op      = op;
      c.epc     = epc;
      c.code    = code;
      c.chk_epc = ce;
      q_cmd.push_back(c);
      q_redir.push_back(tgt);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_cp0op != 3'b000) begin
            if (q_cmd.size() == 0) begin
               check("unexpected_cmd", {29'd0, wr_cp0op}, 32'd0);
            end else begin
               e_cmd = q_cmd.pop_front();
               check("cp0op", {29'd0, wr_cp0op}, {29'd0, e_cmd.op});
               if (e_cmd.chk_epc) begin
                  check("exc_epc", exc_epc, e_cmd.epc);
                  check("exc_code", {27'd0, exc_code}, {27'd0, e_cmd.code});
               end
               check("flush_cmd", {31'd0, flush}, 32'd1);
               check("redir_in_cmd", {31'd0, redirect_valid}, 32'd0);
            end
         end
         if (redirect_valid) begin
            if (q_redir.size() == 0) begin
               check("unexpected_redir", {2'd0, redirect_pc}, 32'd0);
            end else begin
               e_pc = q_redir.pop_front();
               check("redirect_pc", {2'd0, redirect_pc}, {2'd0, e_pc});
               check("flush_redir", {31'd0, flush}, 32'd1);
            end
         end
         if (wr_cp0op == 3'b000 && !redirect_valid)
            check("flush_idle", {31'd0, flush}, 32'd0);
      end
   end

   task automatic check_all_zero(input string pfx);
      check({pfx, "_op"},    {29'd0, wr_cp0op}, 32'd0);
      check({pfx, "_epc"},   exc_epc, 32'd0);
      check({pfx, "_code"},  {27'd0, exc_code}, 32'd0);
      check({pfx, "_flush"}, {31'd0, flush}, 32'd0);
      check({pfx, "_rv"},    {31'd0, redirect_valid}, 32'd0);
      check({pfx, "_rpc"},   {2'd0, redirect_pc}, 32'd0);
      check({pfx, "_kill"},  {31'd0, wb_kill}, 32'd0);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      wb_valid   = 1'b0;
      wb_pc      = '0;
      wb_syscall = 1'b0;
      wb_ovf     = 1'b0;
      wb_eret    = 1'b0;
      irq        = '0;
      status_ie  = 1'b1;
      status_exl = 1'b0;
      status_im  = 6'b000100;
      cp0_epc    = '0;

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // SYSCALL
      push_trap(3'b011, 32'h40, 5'd8, 1'b1, 30'hC00);
      issue(30'h10, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);

      // overflow beats syscall, instruction killed
      push_trap(3'b011, 32'h80, 5'd12, 1'b1, 30'hC00);
      issue(30'h20, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(4);

      // interrupt: two synchronizer cycles before it can be taken
      irq = 6'b000100;
      push_trap(3'b011, 32'hC4, 5'd0, 1'b1, 30'hC00);
      issue(30'h2E, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(30'h2F, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(30'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      irq = '0;
      idle(4);

      // masked by EXL, then by IM
      status_exl = 1'b1;
      irq = 6'b000100;
      idle(3);
      issue(30'h40, 1'b0, 1'b0, 1'b0, 1'b0);
      status_exl = 1'b0;
      status_im  = 6'b000000;
      issue(30'h41, 1'b0, 1'b0, 1'b0, 1'b0);
      status_im  = 6'b000100;
      irq = '0;
      idle(4);

      // exception beats pending interrupt
      irq = 6'b000100;
      idle(3);
      push_trap(3'b011, 32'h140, 5'd8, 1'b1, 30'hC00);
      issue(30'h50, 1'b1, 1'b0, 1'b0, 1'b0);
      irq = '0;
      idle(4);

      // ERET returns to CP0 EPC
      cp0_epc = 30'h31;
      push_trap(3'b100, 32'h0, 5'd0, 1'b0, 30'h31);
      issue(30'h60, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);

      // back-to-back SYSCALLs: only the first is taken
      push_trap(3'b011, 32'h1C0, 5'd8, 1'b1, 30'hC00);
      issue(30'h70, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(30'h71, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(30'h72, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);

      // reset during TRAP aborts; no REDIR afterwards
      wb_valid   = 1'b1;
      wb_pc      = 30'h80;
      wb_syscall = 1'b1;
      @(posedge clk);
      #1;
      wb_valid   = 1'b0;
      wb_syscall = 1'b0;
      check("trap_before_rst", {29'd0, wr_cp0op}, 32'd3);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      idle(2);
      rst_n = 1'b1;
      idle(5);

      check("cmd_queue_empty", q_cmd.size(), 32'd0);
      check("redir_queue_empty", q_redir.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
